// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data-memory access unit: op codes,
// FSM states, bus size codes and small op classification helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB, LBU, LH, LHU, LW, LWU, LD,
    SB, SH, SW, SD,
    LWL, LWR, SWL, SWR
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } mem_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  function automatic logic op_is_load(mem_op_e op);
    return op inside {LB, LBU, LH, LHU, LW, LWU, LD, LWL, LWR};
  endfunction

  function automatic logic op_is_store(mem_op_e op);
    return op inside {SB, SH, SW, SD, SWL, SWR};
  endfunction

  function automatic logic op_is_unaligned(mem_op_e op);
    return op inside {LWL, LWR, SWL, SWR};
  endfunction

  function automatic logic [1:0] op_size(mem_op_e op);
    logic [1:0] size;
    case (op)
      LB, LBU, SB: size = SIZE_B;
      LH, LHU, SH: size = SIZE_H;
      LD, SD:      size = SIZE_D;
      default:     size = SIZE_W;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Signal bundle between the M stage, the access unit and the data bus.
// master = the access unit itself, slave = the M stage plus bus bridge side.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  import mem_pkg::*;

  localparam int BYTES = DATA_W / 8;

  // M-stage side: req_valid presents an op; stall holds the stage until the
  // op is done. rdata_valid marks a load result, consumed when m_allowin = 1.
  logic              req_valid;
  mem_op_e           mem_op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rt_old;
  logic              flush;
  logic              m_allowin;
  logic              stall;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              addr_err_load;
  logic              addr_err_store;
  logic              op_reserved;
  logic [ADDR_W-1:0] badvaddr;

  // Bus side: request fields are stable while data_req = 1; the request is
  // taken in the cycle data_addr_ok = 1, and data_data_ok = 1 returns the
  // read data or acknowledges the write.
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [BYTES-1:0]  data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  mem_state_e        dbg_state;

  modport master (
    input  req_valid, mem_op, addr, wdata, rt_old, flush, m_allowin,
    input  data_addr_ok, data_data_ok, data_rdata,
    output stall, rdata_valid, rdata, addr_err_load, addr_err_store,
    output op_reserved, badvaddr,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output dbg_state
  );

  modport slave (
    output req_valid, mem_op, addr, wdata, rt_old, flush, m_allowin,
    output data_addr_ok, data_data_ok, data_rdata,
    input  stall, rdata_valid, rdata, addr_err_load, addr_err_store,
    input  op_reserved, badvaddr,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  dbg_state
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction/merge for loads, little-endian.
// Purely combinational; the store side and the load side are independent.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_op_e                      i_st_op,
  input  logic [$clog2(DATA_W/8)-1:0]  i_st_ofs,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W/8-1:0]          o_wstrb,
  output logic [DATA_W-1:0]            o_wdata,
  input  mem_op_e                      i_ld_op,
  input  logic [$clog2(DATA_W/8)-1:0]  i_ld_ofs,
  input  logic [DATA_W-1:0]            i_rdata,
  input  logic [31:0]                  i_rt_old,
  output logic [DATA_W-1:0]            o_ld_data
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  logic [OFS_W-1:0]  w_st_wofs;
  logic [1:0]        w_st_o;
  logic [31:0]       w_st_word;
  logic [3:0]        w_st_mask4;
  logic [OFS_W-1:0]  w_ld_wofs;
  logic [1:0]        w_ld_o;
  logic [DATA_W-1:0] w_ld_sh;
  logic [31:0]       w_ld_mem;
  logic [31:0]       w_lwl;
  logic [31:0]       w_lwr;

  // Offset of the 32-bit word lane inside the data path (0 or 4 at 64 bits).
  assign w_st_wofs = i_st_ofs & ~OFS_W'(3);
  assign w_st_o    = i_st_ofs[1:0];

  always_comb begin
    w_st_word  = i_wdata[31:0];
    w_st_mask4 = 4'hF;
    o_wdata    = '0;
    o_wstrb    = '0;
    case (i_st_op)
      SB: begin
        o_wdata = {BYTES{i_wdata[7:0]}};
        o_wstrb = BYTES'(1) << i_st_ofs;
      end
      SH: begin
        o_wdata = {(BYTES/2){i_wdata[15:0]}};
        o_wstrb = BYTES'(2'b11) << i_st_ofs;
      end
      SW: begin
        o_wdata = {(BYTES/4){i_wdata[31:0]}};
        o_wstrb = BYTES'(4'hF) << i_st_ofs;
      end
      SD: begin
        o_wdata = i_wdata;
        o_wstrb = '1;
      end
      SWL: begin
        w_st_word  = i_wdata[31:0] >> {~w_st_o, 3'b000};
        w_st_mask4 = 4'hF >> ~w_st_o;
        o_wdata    = {(BYTES/4){w_st_word}};
        o_wstrb    = BYTES'(w_st_mask4) << w_st_wofs;
      end
      SWR: begin
        w_st_word  = i_wdata[31:0] << {w_st_o, 3'b000};
        w_st_mask4 = 4'hF << w_st_o;
        o_wdata    = {(BYTES/4){w_st_word}};
        o_wstrb    = BYTES'(w_st_mask4) << w_st_wofs;
      end
      default: ;
    endcase
  end

  assign w_ld_wofs = i_ld_ofs & ~OFS_W'(3);
  assign w_ld_o    = i_ld_ofs[1:0];
  assign w_ld_sh   = i_rdata >> {i_ld_ofs, 3'b000};
  assign w_ld_mem  = 32'(i_rdata >> {w_ld_wofs, 3'b000});

  // Memory bytes fill the top (LWL) or bottom (LWR) of the word; the
  // remaining bytes keep the old register value.
  assign w_lwl = (w_ld_mem << {~w_ld_o, 3'b000}) |
                 (i_rt_old & ~(32'hFFFF_FFFF << {~w_ld_o, 3'b000}));
  assign w_lwr = (w_ld_mem >> {w_ld_o, 3'b000}) |
                 (i_rt_old & ~(32'hFFFF_FFFF >> {w_ld_o, 3'b000}));

  always_comb begin
    o_ld_data = '0;
    case (i_ld_op)
      LB:      o_ld_data = DATA_W'($signed(w_ld_sh[7:0]));
      LBU:     o_ld_data = DATA_W'(w_ld_sh[7:0]);
      LH:      o_ld_data = DATA_W'($signed(w_ld_sh[15:0]));
      LHU:     o_ld_data = DATA_W'(w_ld_sh[15:0]);
      LW:      o_ld_data = DATA_W'($signed(w_ld_sh[31:0]));
      LWU:     o_ld_data = DATA_W'(w_ld_sh[31:0]);
      LD:      o_ld_data = w_ld_sh;
      LWL:     o_ld_data = DATA_W'($signed(w_lwl));
      LWR:     o_ld_data = DATA_W'($signed(w_lwr));
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: alignment checks, request/response handshake with
// the data bus, M-stage stall generation and registered load results.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter bit EN_UNALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  mem_access_unit_if.master   mif
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  mem_state_e        r_state;
  mem_state_e        w_next;
  mem_op_e           r_op;
  logic [OFS_W-1:0]  r_ofs;
  logic [31:0]       r_rt_old;
  logic              r_data_wr;
  logic [1:0]        r_data_size;
  logic [ADDR_W-1:0] r_data_addr;
  logic [BYTES-1:0]  r_data_wstrb;
  logic [DATA_W-1:0] r_data_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;

  logic [OFS_W-1:0]  w_ofs;
  logic              w_is_ld;
  logic              w_is_st;
  logic              w_misalign;
  logic              w_reserved;
  logic              w_eval;
  logic              w_err_ld;
  logic              w_err_st;
  logic              w_accept;
  logic              w_stall;
  logic [ADDR_W-1:0] w_req_addr;
  logic [BYTES-1:0]  w_st_wstrb;
  logic [DATA_W-1:0] w_st_wdata;
  logic [DATA_W-1:0] w_ld_data;

  assign w_ofs   = mif.addr[OFS_W-1:0];
  assign w_is_ld = op_is_load(mif.mem_op);
  assign w_is_st = op_is_store(mif.mem_op);

  always_comb begin
    w_misalign = 1'b0;
    w_reserved = 1'b0;
    case (mif.mem_op)
      LH, LHU, SH: w_misalign = mif.addr[0];
      LW, LWU, SW: w_misalign = |mif.addr[1:0];
      LD, SD: begin
        if (DATA_W == 64) w_misalign = |mif.addr[2:0];
        else              w_reserved = 1'b1;
      end
      LWL, LWR, SWL, SWR: w_reserved = !EN_UNALIGNED;
      default: ;
    endcase
  end

  // Faults are only reported for an op the unit is actually looking at.
  assign w_eval   = (r_state == IDLE) && mif.req_valid && (mif.mem_op != NONE);
  assign w_err_ld = w_eval && w_misalign && w_is_ld;
  assign w_err_st = w_eval && w_misalign && w_is_st;
  assign w_accept = w_eval && !w_misalign && !w_reserved && !mif.flush;

  assign w_req_addr = op_is_unaligned(mif.mem_op) ?
                      {mif.addr[ADDR_W-1:2], 2'b00} : mif.addr;

  mem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .i_st_op   (mif.mem_op),
    .i_st_ofs  (w_ofs),
    .i_wdata   (mif.wdata),
    .o_wstrb   (w_st_wstrb),
    .o_wdata   (w_st_wdata),
    .i_ld_op   (r_op),
    .i_ld_ofs  (r_ofs),
    .i_rdata   (mif.data_rdata),
    .i_rt_old  (r_rt_old),
    .o_ld_data (w_ld_data)
  );

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_accept;
        if (w_accept) w_next = REQ;
      end
      REQ: begin
        w_stall = 1'b1;
        if (mif.data_addr_ok) w_next = mif.flush ? DRAIN : WAIT;
        else if (mif.flush)   w_next = IDLE;
      end
      WAIT: begin
        w_stall = 1'b1;
        if (mif.data_data_ok) w_next = mif.flush ? IDLE : DONE;
        else if (mif.flush)   w_next = DRAIN;
      end
      DONE: begin
        if (mif.m_allowin || mif.flush) w_next = IDLE;
      end
      DRAIN: begin
        // An accepted request still owes a response; it is swallowed here.
        w_stall = mif.req_valid;
        if (mif.data_data_ok) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_op          <= NONE;
      r_ofs         <= '0;
      r_rt_old      <= '0;
      r_data_wr     <= 1'b0;
      r_data_size   <= '0;
      r_data_addr   <= '0;
      r_data_wstrb  <= '0;
      r_data_wdata  <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op         <= mif.mem_op;
        r_ofs        <= w_ofs;
        r_rt_old     <= mif.rt_old[31:0];
        r_data_wr    <= w_is_st;
        r_data_size  <= op_size(mif.mem_op);
        r_data_addr  <= w_req_addr;
        r_data_wstrb <= w_st_wstrb;
        r_data_wdata <= w_st_wdata;
      end
      if (r_state == WAIT && mif.data_data_ok && !mif.flush) begin
        r_rdata_valid <= op_is_load(r_op);
        if (op_is_load(r_op)) r_rdata <= w_ld_data;
      end else if (r_state == DONE && (mif.m_allowin || mif.flush)) begin
        r_rdata_valid <= 1'b0;
      end
    end
  end

  assign mif.stall          = w_stall;
  assign mif.rdata_valid    = r_rdata_valid;
  assign mif.rdata          = r_rdata;
  assign mif.addr_err_load  = w_err_ld;
  assign mif.addr_err_store = w_err_st;
  assign mif.op_reserved    = w_eval && w_reserved;
  assign mif.badvaddr       = (w_err_ld || w_err_st || (w_eval && w_reserved)) ?
                              mif.addr : '0;
  assign mif.data_req       = (r_state == REQ);
  assign mif.data_wr        = r_data_wr;
  assign mif.data_size      = r_data_size;
  assign mif.data_addr      = r_data_addr;
  assign mif.data_wstrb     = r_data_wstrb;
  assign mif.data_wdata     = r_data_wdata;
  assign mif.dbg_state      = r_state;

endmodule
